// File: rtl/instr_issue_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instr_issue_seq                                               |
// | Purpose  : Byte-loaded program buffer issued to the compute unit at one  |
// |            instruction per cycle, with a 16-entry shadow of its results. |
// |            Optional build macro SEQ_LOOP_EN adds a looping 'loop' input. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module instr_issue_seq #(
  parameter int DEPTH        = 8,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
`ifdef SEQ_LOOP_EN
  input  logic        loop,
`endif
  input  logic        wr_en,
  input  logic [7:0]  wr_byte,
  input  logic        prog_clr,
  input  logic        start,
  output logic [15:0] instruction,
  output logic        en,
  input  logic [7:0]  res_data,
  input  logic        res_valid,
  input  logic [3:0]  res_reg_id,
  input  logic [3:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [7:0]  res_cnt
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_dw = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [c_aw:0]   c_full       = (c_aw + 1)'(DEPTH);
  localparam logic [c_dw-1:0] c_drain_last = c_dw'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_run   = 2'd1;
  localparam logic [1:0] c_drain = 2'd2;
  localparam logic [1:0] c_done  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [c_aw-1:0] pc_q, pc_d;
  logic [c_aw:0]   wr_ptr_q, wr_ptr_d;
  logic            tog_q, tog_d;
  logic [7:0]      lo_q, lo_d;
  logic            ovf_q, ovf_d;
  logic [c_dw-1:0] drain_q, drain_d;
  logic            en_q, en_d;
  logic [15:0]     instr_q, instr_d;
  logic [7:0]      res_cnt_q, res_cnt_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            mem_we;

  logic [15:0]     mem_q    [DEPTH];
  logic [7:0]      shadow_q [16];

  logic            w_loop;
  logic            w_last;
  logic [c_aw:0]   w_len_m1;

`ifdef SEQ_LOOP_EN
  assign w_loop = loop;
`else
  assign w_loop = 1'b0;
`endif

  assign w_len_m1 = wr_ptr_q - (c_aw + 1)'(1);
  assign w_last   = ({1'b0, pc_q} == w_len_m1);

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= c_idle;
      pc_q      <= '0;
      wr_ptr_q  <= '0;
      tog_q     <= 1'b0;
      lo_q      <= 8'h00;
      ovf_q     <= 1'b0;
      drain_q   <= '0;
      en_q      <= 1'b0;
      instr_q   <= 16'h0000;
      res_cnt_q <= 8'h00;
      rd_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      wr_ptr_q  <= wr_ptr_d;
      tog_q     <= tog_d;
      lo_q      <= lo_d;
      ovf_q     <= ovf_d;
      drain_q   <= drain_d;
      en_q      <= en_d;
      instr_q   <= instr_d;
      res_cnt_q <= res_cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Program storage needs no reset: only entries below wr_ptr are ever issued
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q[c_aw-1:0]] <= {wr_byte, lo_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        shadow_q[i] <= 8'h00;
      end
    end else if (res_valid) begin
      shadow_q[res_reg_id] <= res_data;
    end
  end

  // Next-state and loader logic
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    tog_d    = tog_q;
    lo_d     = lo_q;
    ovf_d    = ovf_q;
    drain_d  = drain_q;
    mem_we   = 1'b0;
    case (state_q)
      c_idle, c_done: begin
        if (prog_clr) begin
          wr_ptr_d = '0;
          tog_d    = 1'b0;
          ovf_d    = 1'b0;
          state_d  = c_idle;
        end else if (start) begin
          pc_d    = '0;
          state_d = (wr_ptr_q != '0) ? c_run : c_done;
        end else if (wr_en) begin
          state_d = c_idle;
          if (wr_ptr_q == c_full) begin
            ovf_d = 1'b1;
          end else if (!tog_q) begin
            lo_d  = wr_byte;
            tog_d = 1'b1;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + (c_aw + 1)'(1);
            tog_d    = 1'b0;
          end
        end
      end
      c_run: begin
        if (w_last) begin
          pc_d = '0;
          if (!w_loop) begin
            drain_d = '0;
            state_d = (DRAIN_CYCLES == 0) ? c_done : c_drain;
          end
        end else begin
          pc_d = pc_q + c_aw'(1);
        end
      end
      c_drain: begin
        if (drain_q == c_drain_last) begin
          state_d = c_done;
        end else begin
          drain_d = drain_q + c_dw'(1);
        end
      end
      default: state_d = c_idle;
    endcase

    // Issue outputs are registered from the next state so they track RUN exactly
    en_d      = (state_d == c_run);
    instr_d   = en_d ? mem_q[pc_d] : 16'h0000;
    res_cnt_d = (res_valid && (res_cnt_q != 8'hFF)) ? res_cnt_q + 8'd1 : res_cnt_q;
    rd_data_d = shadow_q[rd_addr];
  end

  // Output decode
  always_comb begin
    busy        = (state_q == c_run) || (state_q == c_drain);
    done        = (state_q == c_done);
    en          = en_q;
    instruction = instr_q;
    overflow    = ovf_q;
    res_cnt     = res_cnt_q;
    rd_data     = rd_data_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_issue_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_instr_issue_seq                                            |
// | Purpose  : Directed bench for instr_issue_seq with a queue-based model.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_instr_issue_seq;

  localparam int DEPTH = 8;
  localparam int DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst, loop, wr_en, prog_clr, start, res_valid;
  logic [7:0]  wr_byte, res_data;
  logic [3:0]  res_reg_id, rd_addr;
  logic [15:0] instruction;
  logic        en, busy, done, overflow;
  logic [7:0]  rd_data, res_cnt;

  int checks = 0;
  int errors = 0;

  instr_issue_seq #(.DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst),
`ifdef SEQ_LOOP_EN
    .loop(loop),
`endif
    .wr_en(wr_en), .wr_byte(wr_byte), .prog_clr(prog_clr), .start(start),
    .instruction(instruction), .en(en),
    .res_data(res_data), .res_valid(res_valid), .res_reg_id(res_reg_id),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .overflow(overflow), .res_cnt(res_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a program list plus a per-cycle schedule of expected outputs
  typedef struct packed {
    logic        en;
    logic [15:0] ins;
    logic        busy;
    logic        done;
    logic        last;
  } exp_t;

  exp_t        cur;
  exp_t        sched[$];
  logic [15:0] prog[$];
  bit          pend;
  logic [7:0]  lo;
  bit          ovf;
  logic [7:0]  shadow[16];
  int          cnt;
  logic [7:0]  rd;
  bit          mvalid = 1'b0;

  function automatic exp_t mk(logic e, logic [15:0] i, logic b, logic d, logic l);
    exp_t x;
    x.en = e; x.ins = i; x.busy = b; x.done = d; x.last = l;
    return x;
  endfunction

  task automatic model_step();
    if (rst) begin
      cur = mk(0, 0, 0, 0, 0);
      sched.delete(); prog.delete();
      pend = 0; ovf = 0; cnt = 0; rd = 0;
      for (int i = 0; i < 16; i++) shadow[i] = 0;
      mvalid = 1;
    end else begin
      rd = shadow[rd_addr];
      if (res_valid) begin
        shadow[res_reg_id] = res_data;
        if (cnt < 255) cnt++;
      end
      if (cur.busy) begin
`ifdef SEQ_LOOP_EN
        if (cur.last && loop)
          for (int i = prog.size() - 1; i >= 0; i--)
            sched.push_front(mk(1, prog[i], 1, 0, i == prog.size() - 1));
`endif
        if (sched.size() > 0) cur = sched.pop_front();
        else cur = mk(0, 0, 0, 1, 0);
      end else if (prog_clr) begin
        prog.delete(); pend = 0; ovf = 0;
        cur = mk(0, 0, 0, 0, 0);
      end else if (start) begin
        if (prog.size() == 0) begin
          cur = mk(0, 0, 0, 1, 0);
        end else begin
          for (int i = 0; i < prog.size(); i++)
            sched.push_back(mk(1, prog[i], 1, 0, i == prog.size() - 1));
          for (int i = 0; i < DRAIN; i++) sched.push_back(mk(0, 0, 1, 0, 0));
          cur = sched.pop_front();
        end
      end else if (wr_en) begin
        cur.done = 0;
        if (prog.size() == DEPTH) ovf = 1;
        else if (!pend) begin lo = wr_byte; pend = 1; end
        else begin prog.push_back({wr_byte, lo}); pend = 0; end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (mvalid) begin
      chk("en",       16'(en),       16'(cur.en));
      chk("instr",    instruction,   cur.ins);
      chk("busy",     16'(busy),     16'(cur.busy));
      chk("done",     16'(done),     16'(cur.done));
      chk("overflow", 16'(overflow), 16'(ovf));
      chk("res_cnt",  16'(res_cnt),  16'(cnt));
      chk("rd_data",  16'(rd_data),  16'(rd));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wrb(input logic [7:0] b);
    wr_en = 1; wr_byte = b; cyc(); wr_en = 0;
  endtask

  task automatic go();
    start = 1; cyc(); start = 0;
  endtask

  task automatic clr();
    prog_clr = 1; cyc(); prog_clr = 0;
  endtask

  task automatic wait_done(output int n_en);
    n_en = 0;
    for (int k = 0; k < 200 && done !== 1'b1; k++) begin
      if (en === 1'b1) n_en++;
      cyc();
    end
    chk("wait_done", 16'(done), 16'd1);
  endtask

  int n;

  initial begin
    rst = 1; loop = 0; wr_en = 0; wr_byte = 0; prog_clr = 0; start = 0;
    res_valid = 0; res_data = 0; res_reg_id = 0; rd_addr = 0;
    cyc(); cyc(); rst = 0;
    chk("rst_en", 16'(en), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_rd", 16'(rd_data), 16'd0);

    // Three-entry program
    wrb(8'h05); wrb(8'h13); wrb(8'h07); wrb(8'h14); wrb(8'h34); wrb(8'h25);
    go();
    chk("t1_i0", instruction, 16'h1305); chk("t1_en0", 16'(en), 16'd1);
    cyc(); chk("t1_i1", instruction, 16'h1407);
    cyc(); chk("t1_i2", instruction, 16'h2534);
    cyc(); chk("t1_en3", 16'(en), 16'd0); chk("t1_busy3", 16'(busy), 16'd1);
    cyc(); chk("t1_busy4", 16'(busy), 16'd1);
    cyc(); chk("t1_busy5", 16'(busy), 16'd0); chk("t1_done", 16'(done), 16'd1);

    // Result capture and shadow reads
    res_valid = 1; res_reg_id = 4'd3; res_data = 8'h05; cyc();
    res_reg_id = 4'd5; res_data = 8'h0C; cyc(); res_valid = 0;
    rd_addr = 4'd5; cyc(); chk("t2_rd5", 16'(rd_data), 16'h000C); chk("t2_cnt", 16'(res_cnt), 16'd2);
    rd_addr = 4'd3; cyc(); chk("t2_rd3", 16'(rd_data), 16'h0005);
    rd_addr = 4'd5; res_valid = 1; res_reg_id = 4'd5; res_data = 8'h77; cyc(); res_valid = 0;
    chk("t2_rd_old", 16'(rd_data), 16'h000C);
    cyc(); chk("t2_rd_new", 16'(rd_data), 16'h0077); chk("t2_cnt3", 16'(res_cnt), 16'd3);

    // Overflow and empty program
    clr(); chk("t3_idle", 16'(done), 16'd0);
    for (int i = 0; i < 2 * DEPTH + 2; i++) wrb(8'(8'h40 + i));
    chk("t3_ovf", 16'(overflow), 16'd1);
    go(); chk("t3_first", instruction, 16'h4140);
    wait_done(n); chk("t3_len", 16'(n), 16'd8);
    clr(); chk("t3_ovf_clr", 16'(overflow), 16'd0);
    go(); chk("t3_empty_done", 16'(done), 16'd1); chk("t3_empty_en", 16'(en), 16'd0);

    // start beats wr_en; writes during RUN ignored
    clr();
    wrb(8'h05); wrb(8'h13); wrb(8'h07);
    start = 1; wr_en = 1; wr_byte = 8'h99; cyc(); start = 0; wr_en = 0;
    chk("t4_en", 16'(en), 16'd1); chk("t4_i0", instruction, 16'h1305);
    wrb(8'hAA); wrb(8'hBB);
    wait_done(n);
    wrb(8'h14);
    go(); chk("t4_r0", instruction, 16'h1305);
    cyc(); chk("t4_r1", instruction, 16'h1407);
    cyc(); chk("t4_r2", 16'(en), 16'd0);
    wait_done(n);

    // Reset in the middle of RUN
    go(); cyc();
    rst = 1; cyc(); rst = 0;
    chk("t5_en", 16'(en), 16'd0); chk("t5_instr", instruction, 16'h0000);
    chk("t5_busy", 16'(busy), 16'd0); chk("t5_cnt", 16'(res_cnt), 16'd0);
    rd_addr = 4'd5; cyc(); chk("t5_shadow", 16'(rd_data), 16'd0);

`ifdef SEQ_LOOP_EN
    wrb(8'h05); wrb(8'h13); wrb(8'h07); wrb(8'h14);
    loop = 1; go(); chk("t6_i0", instruction, 16'h1305);
    cyc(); chk("t6_i1", instruction, 16'h1407);
    cyc(); chk("t6_i2", instruction, 16'h1305);
    loop = 0;
    cyc(); chk("t6_i3", instruction, 16'h1407);
    cyc(); chk("t6_en4", 16'(en), 16'd0); chk("t6_busy4", 16'(busy), 16'd1);
    wait_done(n);
`endif

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_issue_seq.md
Name: instr_issue_seq

Overview:
- Drives the instruction/enable side of the compute unit and consumes its result stream (data, data_valid, reg_id).
- Holds a small program buffer of 16-bit instructions, loaded a byte at a time from the 8-bit pin bus.
- On start, issues the program to the compute unit at one instruction per cycle, then drains in-flight results.
- Mirrors every returned result into a 16-entry shadow register file that host pins can read.

Parameters:
- DEPTH, 8, program buffer entries; power of two, 2..16.
- DRAIN_CYCLES, 2, idle cycles after the last issue before done; covers compute-unit result latency.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- wr_en  in  1  program byte strobe.
- wr_byte  in  8  program byte; low byte first, then high byte.
- prog_clr  in  1  empty the program buffer.
- start  in  1  begin issuing the program.
- instruction  out  16  instruction to the compute unit.
- en  out  1  instruction valid to the compute unit.
- res_data  in  8  result data from the compute unit.
- res_valid  in  1  result valid.
- res_reg_id  in  4  result target register.
- rd_addr  in  4  shadow register read index.
- rd_data  out  8  shadow register contents; registered.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- overflow  out  1  sticky; a write was attempted while the buffer was full.
- res_cnt  out  8  count of results captured; saturates at 255.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - instruction=0, en=0, busy=0, done=0, overflow=0, res_cnt=0, rd_data=0.
  - wr_ptr=0, byte toggle=low, pc=0, all shadow entries=0.
  - Reset during RUN or DRAIN aborts immediately, with no further en pulses.
- States: IDLE, RUN, DRAIN, DONE.
- Loading (IDLE or DONE only; wr_en ignored in RUN/DRAIN):
  - wr_en with toggle=low: latch the byte as low half; toggle goes high.
  - wr_en with toggle=high: write {wr_byte, low half} to mem[wr_ptr]; wr_ptr+1; toggle goes low.
  - A write in DONE also moves the state to IDLE.
  - If wr_ptr==DEPTH, the byte is dropped, overflow is set, and toggle is unchanged.
  - prog_len = wr_ptr (0..DEPTH). A dangling low byte is never issued.
- prog_clr (IDLE or DONE): wr_ptr=0, toggle=low, overflow=0, state to IDLE. Shadow file and res_cnt are kept.
- start in IDLE or DONE:
  - If prog_len>0: pc=0, go to RUN.
  - If prog_len==0: go directly to DONE; no en pulse.
- RUN, each cycle:
  - instruction=mem[pc], en=1, registered outputs.
  - First en appears the cycle after start is sampled.
  - Exactly prog_len consecutive en cycles.
  - After issuing pc==prog_len-1, go to DRAIN.
- DRAIN: en=0, instruction=0; count DRAIN_CYCLES cycles, then go to DONE.
- DONE: done=1 held until start, wr_en or prog_clr. start re-runs the same program from pc=0.
- start during RUN/DRAIN is ignored.
- Priority within one cycle: rst > prog_clr > start > wr_en. A losing wr_en byte is dropped and does not set overflow.
- Result capture, in every state except reset:
  - res_valid=1 writes shadow[res_reg_id] <= res_data.
  - res_cnt increments and saturates at 255.
- rd_data: rd_data <= shadow[rd_addr], 1-cycle latency.
  - A result write and a read of the same index in one cycle returns the old value; the new value appears next cycle.
- instruction and en change only on clock edges; no combinational path from inputs.

Optional Feature:
- Macro: SEQ_LOOP_EN.
- Defined:
  - Adds input port loop (1 bit).
  - In RUN, after issuing the last entry with loop=1, pc wraps to 0 and RUN continues with no gap cycle.
  - With loop=0 at that point, go to DRAIN.
  - Loop is sampled only at the last-entry cycle.
- Undefined:
  - loop port absent.
  - RUN always ends in DRAIN after one pass.

Test Plan:
- Load 0x1305, 0x1407, 0x2534 (bytes 05,13,07,14,34,25), pulse start -> en high exactly 3 cycles starting one cycle after start with instruction 0x1305, 0x1407, 0x2534; busy for 3+2 cycles; done=1 after.
- Drive res_valid with (reg 3, 0x05), then (reg 5, 0x0C); rd_addr=5 -> rd_data=0x0C one cycle later, res_cnt=2; rd_addr=3 -> 0x05.
- Write 2*DEPTH+2 bytes (18 at default) -> entries 0..7 stored, overflow=1, prog_len=8; prog_clr -> overflow=0, start gives 0 en cycles and done=1.
- Assert start and wr_en in the same IDLE cycle -> RUN entered, byte dropped, toggle unchanged; wr_en during RUN -> mem unchanged.
- Assert rst on the 2nd RUN cycle -> next cycle en=0, instruction=0, busy=0; shadow entries=0.
- With SEQ_LOOP_EN and loop=1 for 2 passes of a 2-entry program -> 4 contiguous en cycles 0x1305, 0x1407, 0x1305, 0x1407, then DRAIN.
